burst_capture: RTL and testbench
================================

# burst_capture

Downstream consumer of the power trigger. Continuously writes I/Q samples into a circular buffer while armed, and on a trigger freezes a window of `pretrig` samples before the trigger plus `posttrig` samples from the trigger onward. It then drains that window in order over a ready/valid stream to the readout/DMA stage. A run captures one burst, then returns to idle until re-armed.

## Interface
- `DEPTH`, 1024, buffer depth in samples; power of two, ≥ 4
- `ADDR_W`, $clog2(DEPTH), buffer address width (derived, not overridden)
- `clock`  in  1  sole clock
- `reset`  in  1  synchronous, active-high
- `enable`  in  1  sample strobe; `sample` and `trigger` qualify only when high
- `sample`  in  32  I/Q sample, I in [31:16], Q in [15:0], stored verbatim
- `trigger`  in  1  trigger from the power trigger, qualified by `enable`
- `arm`  in  1  single-cycle start request, honoured in IDLE only
- `pretrig`  in  16  samples kept before the trigger, latched on accepted `arm`
- `posttrig`  in  16  samples kept from the trigger on, latched on accepted `arm`
- `out_data`  out  32  drained sample
- `out_valid`  out  1  `out_data` valid
- `out_ready`  in  1  downstream accept
- `out_last`  out  1  high with the final drained sample
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse the cycle after the last beat is accepted

## Operation
- States: IDLE → FILL → ARMED → POST → DRAIN → IDLE.
- Latch on `arm` in IDLE, then clamp:
  - P = min(`pretrig`, DEPTH−1)
  - N = max(1, min(`posttrig`, DEPTH−P))
  - P + N ≤ DEPTH always holds.
- Write pointer `wp` resets to 0 on arm. Every qualified sample in FILL, ARMED and POST is written at `wp`, then `wp` increments modulo DEPTH (wrap is natural).
- FILL: count qualified writes. Go to ARMED once P samples are written. If P=0, skip FILL and go straight from IDLE to ARMED. A `trigger` during FILL is ignored.
- ARMED: on a qualified `trigger`, that cycle's sample is post index 0. Record start = (`wp` − P) mod DEPTH. Go to POST with post count 1, or straight to DRAIN if N=1.
- POST: write until N post samples are stored, then go to DRAIN. `trigger` is ignored.
- DRAIN:
  - Read P+N words starting at start, incrementing modulo DEPTH.
  - `sample`, `enable` and `trigger` are ignored.
  - `out_last` is high on beat P+N−1.
  - After that beat is accepted, go to IDLE and pulse `done`.
- `arm` outside IDLE is ignored. An `arm` coinciding with the final accepted beat is also ignored, because the block is still in DRAIN that cycle.
- Reset at any point:
  - State goes to IDLE; all outputs go to 0 the next cycle.
  - Buffer contents are irrelevant and not cleared.
  - A partial drain is abandoned.

## Timing
- Reset values: `out_data`=0, `out_valid`=0, `out_last`=0, `busy`=0, `done`=0.
- `busy` rises the cycle after an accepted `arm`.
- Buffer RAM has synchronous read, 1-cycle latency.
- First `out_valid` rises exactly 2 cycles after the cycle DRAIN is entered.
- Output stage is a 2-entry skid:
  - Sustains one beat per cycle while `out_ready` is held high.
  - No combinational path from `out_ready` to `out_valid` or `out_data`.
- While `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` hold stable.
- `out_valid` never drops without a handshake, except on reset.
- `done` is high the cycle after the last handshake. `busy` falls on the same edge.

## Structure
- `burst_capture_pkg`: state enum (IDLE=0, FILL=1, ARMED=2, POST=3, DRAIN=4, 3-bit), `SAMPLE_W`=32.
- Sub-module `capture_ram`: simple dual-port RAM, DEPTH×32, one write port, one registered read port, no reset on storage.
- FSM, pointers, counters and skid buffer live in `burst_capture`.

## Test plan
- DEPTH=16, P=4, N=4; samples are an incrementing counter 0,1,2,…; trigger at value 9 with `out_ready`=1 → drain 5,6,7,8,9,10,11,12, one per cycle; `out_last` on 12; `done` pulses once.
- P=0, N=1; trigger on the first qualified sample 0x00010002 → single beat 0x00010002 with `out_last`=1.
- DEPTH=16, P=20, N=20 → clamped to P=15, N=1; exactly 16 beats; the pre-window wraps `wp` correctly.
- Toggle `out_ready` 1,0,0,1 pseudo-randomly during drain → sequence intact, no duplicates or drops, data stable while stalled.
- `trigger` pulsed during FILL and POST, `arm` pulsed during DRAIN → no effect; output identical to the clean run.
- `reset` asserted on beat 3 of 8 → next cycle `out_valid`=0 and `busy`=0; a new `arm` captures correctly.

Source files
------------

// File: rtl/burst_capture_pkg.sv
// Shared types and widths for the burst capture block.
package burst_capture_pkg;

    localparam int SAMPLE_W = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        ARMED = 3'd2,
        POST  = 3'd3,
        DRAIN = 3'd4
    } state_e;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample RAM: one write port, registered read port (1-cycle latency).
// No reset on storage or read data; no backpressure.
module capture_ram
    import burst_capture_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int DATA_W = SAMPLE_W
) (
    input  logic              clock,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_dat_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [DATA_W-1:0] rd_dat_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_dat_i;
        end
        if (rd_en_i) begin
            rd_dat_o <= mem_q[rd_addr_i];
        end
    end

endmodule

// File: rtl/burst_capture.sv
// Circular pre/post-trigger capture of I/Q samples, drained as a ready/valid burst.
// First beat 2 cycles after DRAIN entry; 2-entry skid output, reads throttled by credits.
module burst_capture
    import burst_capture_pkg::*;
#(
    parameter int DEPTH = 1024,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] sample,
    input  logic        trigger,
    input  logic        arm,
    input  logic [15:0] pretrig,
    input  logic [15:0] posttrig,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    localparam int CNT_W = ADDR_W + 1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wp_q, wp_d;
    logic [ADDR_W-1:0]   rp_q, rp_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    p_q, p_d;
    logic [CNT_W-1:0]    n_q, n_d;
    logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
    logic                done_q, done_d;
    logic                rv_q, rv_d;
    logic                rl_q, rl_d;
    logic [1:0]          occ_q, occ_d;
    logic [SAMPLE_W-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
    logic                last0_q, last0_d, last1_q, last1_d;

    logic                wr_en;
    logic                rd_en;
    logic [SAMPLE_W-1:0] ram_rdat;
    logic [31:0]         p_lim, n_room, n_lim;
    logic [CNT_W-1:0]    cnt_inc;
    logic [CNT_W-1:0]    total;
    logic [2:0]          lvl;
    logic                pop;

    capture_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (SAMPLE_W)
    ) u_ram (
        .clock     (clock),
        .wr_en_i   (wr_en),
        .wr_addr_i (wp_q),
        .wr_dat_i  (sample),
        .rd_en_i   (rd_en),
        .rd_addr_i (rp_q),
        .rd_dat_o  (ram_rdat)
    );

    assign out_valid = (occ_q != 2'd0);
    assign out_data  = ent0_q;
    assign out_last  = last0_q && out_valid;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

    assign pop     = out_valid && out_ready;
    assign cnt_inc = cnt_q + CNT_W'(1);
    assign total   = p_q + n_q;
    // Skid entries already held plus the read whose data lands this cycle.
    assign lvl     = {1'b0, occ_q} + {2'b0, rv_q};

    always_comb begin
        state_d  = state_q;
        wp_d     = wp_q;
        rp_d     = rp_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        n_d      = n_q;
        rd_cnt_d = rd_cnt_q;
        done_d   = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;

        p_lim  = (32'(pretrig) > 32'(DEPTH - 1)) ? 32'(DEPTH - 1) : 32'(pretrig);
        n_room = 32'(DEPTH) - p_lim;
        n_lim  = (32'(posttrig) > n_room) ? n_room : 32'(posttrig);
        if (n_lim == 32'd0) begin
            n_lim = 32'd1;
        end

        case (state_q)
            IDLE: begin
                if (arm) begin
                    p_d     = CNT_W'(p_lim);
                    n_d     = CNT_W'(n_lim);
                    wp_d    = '0;
                    cnt_d   = '0;
                    state_d = (p_lim == 32'd0) ? ARMED : FILL;
                end
            end
            FILL: begin
                if (enable) begin
                    wr_en = 1'b1;
                    wp_d  = wp_q + ADDR_W'(1);
                    cnt_d = cnt_inc;
                    if (cnt_inc == p_q) begin
                        state_d = ARMED;
                    end
                end
            end
            ARMED: begin
                if (enable) begin
                    wr_en = 1'b1;
                    wp_d  = wp_q + ADDR_W'(1);
                    if (trigger) begin
                        rp_d     = wp_q - ADDR_W'(p_q);
                        cnt_d    = CNT_W'(1);
                        rd_cnt_d = '0;
                        state_d  = (n_q == CNT_W'(1)) ? DRAIN : POST;
                    end
                end
            end
            POST: begin
                if (enable) begin
                    wr_en = 1'b1;
                    wp_d  = wp_q + ADDR_W'(1);
                    cnt_d = cnt_inc;
                    if (cnt_inc == n_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Issue only if the word still fits once it reaches the skid next cycle.
                if ((rd_cnt_q != total) && (lvl <= 3'd1 + {2'b0, pop})) begin
                    rd_en    = 1'b1;
                    rp_d     = rp_q + ADDR_W'(1);
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
                end
                if (pop && last0_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        rv_d = rd_en;
        rl_d = rd_en && (rd_cnt_q == total - CNT_W'(1));
    end

    always_comb begin
        occ_d   = occ_q;
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        last0_d = last0_q;
        last1_d = last1_q;
        case (occ_q)
            2'd0: begin
                if (rv_q) begin
                    ent0_d  = ram_rdat;
                    last0_d = rl_q;
                    occ_d   = 2'd1;
                end
            end
            2'd1: begin
                if (rv_q && pop) begin
                    ent0_d  = ram_rdat;
                    last0_d = rl_q;
                end else if (rv_q) begin
                    ent1_d  = ram_rdat;
                    last1_d = rl_q;
                    occ_d   = 2'd2;
                end else if (pop) begin
                    occ_d = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    ent0_d  = ent1_q;
                    last0_d = last1_q;
                    if (rv_q) begin
                        ent1_d  = ram_rdat;
                        last1_d = rl_q;
                    end else begin
                        occ_d = 2'd1;
                    end
                end
            end
            default: occ_d = 2'd0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            wp_q     <= '0;
            rp_q     <= '0;
            cnt_q    <= '0;
            p_q      <= '0;
            n_q      <= '0;
            rd_cnt_q <= '0;
            done_q   <= 1'b0;
            rv_q     <= 1'b0;
            rl_q     <= 1'b0;
            occ_q    <= 2'd0;
            ent0_q   <= '0;
            ent1_q   <= '0;
            last0_q  <= 1'b0;
            last1_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            n_q      <= n_d;
            rd_cnt_q <= rd_cnt_d;
            done_q   <= done_d;
            rv_q     <= rv_d;
            rl_q     <= rl_d;
            occ_q    <= occ_d;
            ent0_q   <= ent0_d;
            ent1_q   <= ent1_d;
            last0_q  <= last0_d;
            last1_q  <= last1_d;
        end
    end

endmodule

// File: tb/tb_burst_capture.sv
// Randomized bench for burst_capture (DEPTH=16) against a sample-history reference model.
module tb_burst_capture;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] smp;
    logic        trg;
    logic        arm_s;
    logic [15:0] pre;
    logic [15:0] post;
    logic [31:0] out_data;
    logic        out_valid;
    logic        ordy;
    logic        out_last;
    logic        busy;
    logic        done;

    burst_capture #(.DEPTH(DEPTH)) dut (
        .clock     (clk),
        .reset     (rst),
        .enable    (en),
        .sample    (smp),
        .trigger   (trg),
        .arm       (arm_s),
        .pretrig   (pre),
        .posttrig  (post),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (ordy),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [31:0] got_q[$];
    bit          got_last_q[$];
    logic [31:0] exp_q[$];
    int          stall_viol, done_pulses, first_valid, first_acc, last_acc, fin_k;
    bit          timed_out, busy_after_arm, done_next, busy_next;
    logic        rst_vld, rst_busy, rst_last, rst_done;

    // Drives one arm/fill/trigger/post sequence and collects the drained burst.
    // Expected window is taken straight from the history of qualified samples.
    task automatic capture(input int p_raw, input int n_raw, input int extra_pre,
                           input logic [31:0] base, input bit rand_data, input bit stray,
                           input bit rand_en, input bit rand_rdy, input int abort_beat);
        int          P, N, trig, idx, k;
        logic [31:0] hist[$];
        logic [31:0] v;
        bit          prev_stall;
        logic [31:0] prev_dat;
        logic        prev_last;

        P = (p_raw > DEPTH - 1) ? DEPTH - 1 : p_raw;
        N = (n_raw > DEPTH - P) ? DEPTH - P : n_raw;
        if (N < 1) N = 1;
        trig = P + extra_pre;
        got_q.delete(); got_last_q.delete(); exp_q.delete();
        stall_viol = 0; done_pulses = 0; first_valid = -1; first_acc = -1;
        last_acc = -1; fin_k = -1; timed_out = 0; done_next = 0; busy_next = 1;
        prev_stall = 0; prev_dat = '0; prev_last = 0;

        @(posedge clk); #1;
        arm_s = 1; pre = 16'(p_raw); post = 16'(n_raw); en = 0; trg = 0; ordy = 0;
        @(posedge clk); #1;
        arm_s = 0; pre = 16'($urandom); post = 16'($urandom);

        idx = 0; k = 0;
        while (idx < trig + N) begin
            en  = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
            trg = 0;
            if (en) begin
                v = rand_data ? $urandom : base + 32'(idx);
                smp = v;
                hist.push_back(v);
                trg = (idx == trig) || (stray && (idx < P || idx > trig) && ($urandom_range(0, 1) == 1));
                idx++;
            end else begin
                smp = $urandom;
                trg = stray && ($urandom_range(0, 1) == 1);
            end
            @(negedge clk);
            if (k == 0) busy_after_arm = busy;
            k++;
            @(posedge clk); #1;
        end
        for (int i = trig - P; i < trig + N; i++) exp_q.push_back(hist[i]);

        for (k = 0; k < 200; k++) begin
            if (abort_beat >= 0 && got_q.size() == abort_beat) begin
                rst = 1;
                @(posedge clk); #1;
                rst = 0; en = 0; trg = 0; arm_s = 0;
                @(negedge clk);
                rst_vld = out_valid; rst_busy = busy; rst_last = out_last; rst_done = done;
                @(posedge clk); #1;
                return;
            end
            ordy = rand_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (stray && fin_k < 0) begin
                en = $urandom_range(0, 1) == 1; smp = $urandom; trg = $urandom_range(0, 1) == 1;
                arm_s = $urandom_range(0, 2) == 0;
            end else begin
                en = 0; trg = 0; arm_s = 0;
            end
            @(negedge clk);
            if (out_valid && first_valid < 0) first_valid = k;
            if (prev_stall && (!out_valid || out_data !== prev_dat || out_last !== prev_last)) stall_viol++;
            if (done) done_pulses++;
            if (out_valid && ordy) begin
                got_q.push_back(out_data);
                got_last_q.push_back(out_last);
                if (first_acc < 0) first_acc = k;
                last_acc = k;
                if (out_last && fin_k < 0) fin_k = k;
            end
            prev_stall = out_valid && !ordy; prev_dat = out_data; prev_last = out_last;
            if (fin_k >= 0 && k == fin_k + 1) begin done_next = done; busy_next = busy; end
            if (fin_k >= 0 && k == fin_k + 4) break;
            @(posedge clk); #1;
        end
        if (fin_k < 0 || k >= 200) timed_out = 1;
        @(posedge clk); #1;
        en = 0; trg = 0; arm_s = 0; ordy = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else pass_cnt++;
        total_cnt++; if (out_data !== 32'd0) $display("FAIL reset_data got %h want 0", out_data); else pass_cnt++;
        total_cnt++; if (out_last !== 1'b0) $display("FAIL reset_last got %b want 0", out_last); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass_cnt++;
        @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic test_basic();
        int nlast;
        capture(4, 4, 5, 32'd0, 0, 0, 0, 0, -1);
        total_cnt++; if (busy_after_arm !== 1'b1) $display("FAIL basic_busy_rise got %b want 1", busy_after_arm); else pass_cnt++;
        total_cnt++; if (got_q.size() !== 8) $display("FAIL basic_len got %0d want 8", got_q.size()); else pass_cnt++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total_cnt++;
            if (got_q[i] !== exp_q[i] || got_q[i] !== 32'(5 + i)) $display("FAIL basic_beat%0d got %h want %h", i, got_q[i], 5 + i);
            else pass_cnt++;
        end
        nlast = 0;
        foreach (got_last_q[i]) if (got_last_q[i]) nlast++;
        total_cnt++; if (nlast !== 1 || got_last_q.size() == 0 || got_last_q[got_last_q.size()-1] !== 1'b1)
            $display("FAIL basic_last got %0d lasts want 1 on final beat", nlast); else pass_cnt++;
        total_cnt++; if (first_valid !== 2) $display("FAIL basic_first_valid got %0d want 2", first_valid); else pass_cnt++;
        total_cnt++; if (last_acc - first_acc !== 7) $display("FAIL basic_throughput got %0d want 7", last_acc - first_acc); else pass_cnt++;
        total_cnt++; if (done_pulses !== 1) $display("FAIL basic_done_pulses got %0d want 1", done_pulses); else pass_cnt++;
        total_cnt++; if (done_next !== 1'b1 || busy_next !== 1'b0)
            $display("FAIL basic_done_busy got done=%b busy=%b want 1 0", done_next, busy_next); else pass_cnt++;
    endtask

    task automatic test_pzero();
        capture(0, 1, 0, 32'h00010002, 0, 0, 0, 0, -1);
        total_cnt++; if (got_q.size() !== 1) $display("FAIL pzero_len got %0d want 1", got_q.size()); else pass_cnt++;
        total_cnt++; if (got_q.size() == 0 || got_q[0] !== 32'h00010002)
            $display("FAIL pzero_data got %h want 00010002", got_q.size() ? got_q[0] : 32'hx); else pass_cnt++;
        total_cnt++; if (got_last_q.size() == 0 || got_last_q[0] !== 1'b1) $display("FAIL pzero_last got 0 want 1"); else pass_cnt++;
        total_cnt++; if (first_valid !== 2) $display("FAIL pzero_first_valid got %0d want 2", first_valid); else pass_cnt++;
        total_cnt++; if (done_pulses !== 1) $display("FAIL pzero_done got %0d want 1", done_pulses); else pass_cnt++;
    endtask

    task automatic test_clamp();
        int bad, nlast;
        capture(20, 20, 5, 32'h100, 0, 0, 1, 0, -1);
        total_cnt++; if (got_q.size() !== 16) $display("FAIL clamp_len got %0d want 16", got_q.size()); else pass_cnt++;
        bad = 0; nlast = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
        foreach (got_last_q[i]) if (got_last_q[i]) nlast++;
        total_cnt++; if (bad !== 0) $display("FAIL clamp_data got %0d bad beats want 0", bad); else pass_cnt++;
        total_cnt++; if (got_q.size() == 0 || got_q[0] !== 32'h105) $display("FAIL clamp_first got %h want 105", got_q.size() ? got_q[0] : 32'hx); else pass_cnt++;
        total_cnt++; if (nlast !== 1 || got_last_q.size() == 0 || got_last_q[got_last_q.size()-1] !== 1'b1)
            $display("FAIL clamp_last got %0d lasts want 1 on final", nlast); else pass_cnt++;
        total_cnt++; if (done_pulses !== 1) $display("FAIL clamp_done got %0d want 1", done_pulses); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int bad;
        capture(5, 6, 3, 32'd0, 1, 0, 1, 1, -1);
        total_cnt++; if (timed_out !== 1'b0) $display("FAIL bp_timeout got %b want 0", timed_out); else pass_cnt++;
        total_cnt++; if (got_q.size() !== exp_q.size()) $display("FAIL bp_len got %0d want %0d", got_q.size(), exp_q.size()); else pass_cnt++;
        bad = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
        total_cnt++; if (bad !== 0) $display("FAIL bp_data got %0d bad beats want 0", bad); else pass_cnt++;
        total_cnt++; if (stall_viol !== 0) $display("FAIL bp_stall_stable got %0d violations want 0", stall_viol); else pass_cnt++;
        total_cnt++; if (done_pulses !== 1) $display("FAIL bp_done got %0d want 1", done_pulses); else pass_cnt++;
    endtask

    task automatic test_noise();
        int bad;
        capture(4, 4, 5, 32'd0, 0, 1, 1, 1, -1);
        total_cnt++; if (got_q.size() !== 8) $display("FAIL noise_len got %0d want 8", got_q.size()); else pass_cnt++;
        bad = 0;
        for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== 32'(5 + i)) bad++;
        total_cnt++; if (bad !== 0) $display("FAIL noise_data got %0d bad beats want 0", bad); else pass_cnt++;
        total_cnt++; if (stall_viol !== 0) $display("FAIL noise_stall got %0d want 0", stall_viol); else pass_cnt++;
        total_cnt++; if (busy_next !== 1'b0) $display("FAIL noise_rearm got busy=%b want 0", busy_next); else pass_cnt++;
        total_cnt++; if (done_pulses !== 1) $display("FAIL noise_done got %0d want 1", done_pulses); else pass_cnt++;
    endtask

    task automatic test_reset_mid_drain();
        int bad;
        capture(4, 4, 5, 32'd0, 0, 0, 0, 0, 3);
        total_cnt++; if (rst_vld !== 1'b0) $display("FAIL midrst_valid got %b want 0", rst_vld); else pass_cnt++;
        total_cnt++; if (rst_busy !== 1'b0) $display("FAIL midrst_busy got %b want 0", rst_busy); else pass_cnt++;
        total_cnt++; if (rst_last !== 1'b0 || rst_done !== 1'b0)
            $display("FAIL midrst_last_done got last=%b done=%b want 0 0", rst_last, rst_done); else pass_cnt++;
        capture(3, 5, 2, 32'd0, 1, 0, 0, 1, -1);
        bad = 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
        total_cnt++; if (got_q.size() !== 8 || bad !== 0)
            $display("FAIL midrst_recapture got len=%0d bad=%0d want len=8 bad=0", got_q.size(), bad); else pass_cnt++;
    endtask

    task automatic test_random();
        int bad, nlast;
        for (int r = 0; r < 10; r++) begin
            capture($urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 20), 32'd0,
                    1, $urandom_range(0, 1) == 1, 1, 1, -1);
            bad = 0; nlast = 0;
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) if (got_q[i] !== exp_q[i]) bad++;
            foreach (got_last_q[i]) if (got_last_q[i]) nlast++;
            total_cnt++; if (got_q.size() !== exp_q.size() || bad !== 0)
                $display("FAIL rand%0d_data got len=%0d bad=%0d want len=%0d bad=0", r, got_q.size(), bad, exp_q.size()); else pass_cnt++;
            total_cnt++; if (nlast !== 1 || got_last_q.size() == 0 || got_last_q[got_last_q.size()-1] !== 1'b1)
                $display("FAIL rand%0d_last got %0d lasts want 1 on final", r, nlast); else pass_cnt++;
            total_cnt++; if (first_valid !== 2 || stall_viol !== 0 || done_pulses !== 1)
                $display("FAIL rand%0d_timing got fv=%0d stall=%0d done=%0d want 2 0 1", r, first_valid, stall_viol, done_pulses); else pass_cnt++;
        end
    endtask

    initial begin
        rst = 1; en = 0; smp = '0; trg = 0; arm_s = 0; pre = '0; post = '0; ordy = 0;
        test_reset();
        test_basic();
        test_pzero();
        test_clamp();
        test_backpressure();
        test_noise();
        test_reset_mid_drain();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
